// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches to instruction memory and
// buffers returned words in a small FIFO that feeds the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_current_out,
    output logic [31:0] pc_next_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];

    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          resp_fire;
    logic          resp_keep;
    logic          pop;
    logic [31:0]   resp_addr;
    logic [31:0]   target_pc;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign occupancy      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_fire      = imem_resp_valid;
    assign resp_keep      = resp_fire && (drop_cnt == '0) && !redirect_valid;
    assign target_pc      = redirect_pc & ~32'h3;

    // Once every stale response is gone, the in-flight requests are a contiguous run ending at pc-4.
    assign resp_addr = pc - {{(30-CW){1'b0}}, outstanding, 2'b00};

    assign fetch_valid     = (fifo_count != '0) && !redirect_valid;
    assign pop             = fetch_valid && !stall;
    assign instruction_out = fetch_valid ? fifo_data[rd_ptr] : 32'h0;
    assign pc_current_out  = fetch_valid ? fifo_addr[rd_ptr] : 32'h0;
    assign pc_next_out     = fetch_valid ? fifo_addr[rd_ptr] + 32'd4 : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (redirect_valid) begin
                pc         <= target_pc;
                drop_cnt   <= outstanding - CW'(resp_fire);
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (resp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - 1'b1;
                if (resp_keep)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                fifo_count <= fifo_count + CW'(resp_keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_keep) begin
            fifo_data[wr_ptr] <= imem_resp_data;
            fifo_addr[wr_ptr] <= resp_addr;
        end
    end

endmodule
